ysyx_24110015_mem_arbiter: RTL and testbench

//  Shares the single pmem port (DPI pmem_read/pmem_write) between the IFU (read-only) and the LSU (read/write).

---
 rtl/ysyx_24110015_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ysyx_24110015_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Shares one pmem port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight; LSU has priority unless the IFU has waited MAX_WAIT cycles.
module ysyx_24110015_mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [7:0]         wmask_q, wmask_d;
  logic [31:0]        ifu_rdata_q, ifu_rdata_d;
  logic [31:0]        lsu_rdata_q, lsu_rdata_d;

  logic ifu_starved;
  logic ifu_win;
  logic lsu_win;

  // Grants are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    ifu_starved = (wait_cnt_q >= CNT_W'(MAX_WAIT));
    ifu_win     = !rst && (state_q == S_IDLE) && ifu_req_valid &&
                  (!lsu_req_valid || ifu_starved);
    lsu_win     = !rst && (state_q == S_IDLE) && lsu_req_valid && !ifu_win;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ifu_win || lsu_win) state_d = S_REQ;
      S_REQ:  if (mem_req_ready)      state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid)     state_d = S_RESP;
      S_RESP:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ifu_req_ready  = ifu_win;
    lsu_req_ready  = lsu_win;
    mem_req_valid  = (state_q == S_REQ);
    ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
    ifu_rdata      = ifu_rdata_q;
    lsu_rdata      = lsu_rdata_q;
  end

  // Request latch, owner tracking and per-requester read data
  always_comb begin
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;

    if (ifu_win) begin
      owner_d = OWN_IFU;
      addr_d  = ifu_addr;
      wen_d   = 1'b0;
      wdata_d = 32'h0;
      wmask_d = 8'h0;
    end else if (lsu_win) begin
      owner_d = OWN_LSU;
      addr_d  = lsu_addr;
      wen_d   = lsu_wen;
      wdata_d = lsu_wdata;
      wmask_d = lsu_wmask;
    end

    // Read data lives in a per-owner register so each side holds its last word.
    if ((state_q == S_WAIT) && mem_resp_valid) begin
      if (owner_q == OWN_IFU) begin
        ifu_rdata_d = mem_rdata;
      end else if (owner_q == OWN_LSU) begin
        lsu_rdata_d = wen_q ? 32'h0 : mem_rdata;
      end
    end

    if (state_q == S_RESP) begin
      owner_d = OWN_NONE;
    end
  end

  // Counts refused IFU cycles in every state, not only IDLE.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ifu_req_valid || ifu_win) begin
      wait_cnt_d = '0;
    end else if (!ifu_starved) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 8'h0;
      ifu_rdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a small memory responder.
`timescale 1ns/1ps
module tb_ysyx_24110015_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  ysyx_24110015_mem_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: holds ready low req_delay cycles, answers resp_delay cycles after accept.
  int          req_delay = 0;
  int          resp_delay = 0;
  logic [31:0] model_rdata = 32'h0;
  int          field_changes = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [7:0]  snap_wmask;
  logic        snap_wen;

  initial begin
    int phase = 0;
    int rcnt = 0;
    int scnt = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'hBAD0BAD0;
      if (rst) begin
        phase = 0; rcnt = 0; scnt = 0;
      end else if (phase == 0 && mem_req_valid) begin
        if (rcnt == 0) begin
          snap_addr = mem_addr; snap_wdata = mem_wdata;
          snap_wmask = mem_wmask; snap_wen = mem_wen;
        end else if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !==
                     {snap_addr, snap_wdata, snap_wmask, snap_wen}) begin
          field_changes++;
        end
        if (rcnt >= req_delay) begin
          mem_req_ready = 1'b1;
          phase = 1;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else if (phase == 1) begin
        if (scnt >= resp_delay) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = model_rdata;
          phase = 0;
          scnt = 0;
        end else begin
          scnt++;
        end
      end
    end
  end

  int ifu_resp_cnt = 0, lsu_resp_cnt = 0, lsu_rdy_cnt = 0;
  always @(negedge clk) begin
    if (ifu_resp_valid) ifu_resp_cnt++;
    if (lsu_resp_valid) lsu_resp_cnt++;
    if (lsu_req_ready)  lsu_rdy_cnt++;
  end

  initial begin
    int t0, n, lresp0, lrdy0, fc0;
    bit got;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {58'h0, ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                     mem_req_valid, mem_wen}, 64'h0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
    chk("rst_wmask", {56'h0, mem_wmask}, 64'h0);
    @(negedge clk) rst = 1'b0;
    step();

    // IFU-only fetch, zero-wait memory
    ifu_addr = 32'h8000_0000; model_rdata = 32'h0000_0413; ifu_req_valid = 1;
    #1;
    chk("ifu_ready", {63'h0, ifu_req_ready}, 64'h1);
    chk("ifu_lsu_ready_low", {63'h0, lsu_req_ready}, 64'h0);
    step(); ifu_req_valid = 0;
    chk("ifu_req_fields", {mem_req_valid, mem_wen, mem_wmask, mem_addr}, {1'b1, 1'b0, 8'h0, 32'h8000_0000});
    step(); step();
    chk("ifu_resp_t3", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h2);
    chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
    step();
    chk("ifu_resp_pulse_end", {63'h0, ifu_resp_valid}, 64'h0);
    $display("txn ifu fetch addr=80000000 rdata=%08h", ifu_rdata);

    // LSU write
    lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    model_rdata = 32'hFFFF_FFFF; lsu_req_valid = 1;
    #1;
    chk("wr_ready", {63'h0, lsu_req_ready}, 64'h1);
    step(); lsu_req_valid = 0;
    chk("wr_req_ctl", {54'h0, mem_req_valid, mem_wen, mem_wmask}, {54'h0, 2'b11, 8'h0F});
    chk("wr_req_data", {mem_addr, mem_wdata}, {32'h8000_1000, 32'hDEAD_BEEF});
    step(); step();
    chk("wr_resp", {62'h0, lsu_resp_valid, ifu_resp_valid}, 64'h2);
    chk("wr_rdata_zero", lsu_rdata, 32'h0);
    chk("ifu_rdata_held", ifu_rdata, 32'h0000_0413);
    step();
    lsu_wen = 0;
    $display("txn lsu write addr=80001000 wdata=deadbeef wmask=0f");

    // Contention with wait_cnt=0: LSU first, then IFU
    lsu_addr = 32'h8000_2000; model_rdata = 32'h1234_5678; lsu_req_valid = 1;
    ifu_addr = 32'h8000_0004; ifu_req_valid = 1;
    #1;
    chk("cont_grant", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h2);
    step(); lsu_req_valid = 0;
    chk("cont_lsu_addr", mem_addr, 32'h8000_2000);
    step(); step();
    chk("cont_lsu_resp", {62'h0, lsu_resp_valid, ifu_resp_valid}, 64'h2);
    chk("cont_lsu_rdata", lsu_rdata, 32'h1234_5678);
    model_rdata = 32'h0010_0093;
    step();
    chk("cont_ifu_grant", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h1);
    step(); ifu_req_valid = 0;
    chk("cont_ifu_addr", mem_addr, 32'h8000_0004);
    step(); step();
    chk("cont_ifu_resp", {62'h0, lsu_resp_valid, ifu_resp_valid}, 64'h1);
    chk("cont_ifu_rdata", ifu_rdata, 32'h0010_0093);
    chk("cont_lsu_rdata_held", lsu_rdata, 32'h1234_5678);
    step();
    $display("txn contention lsu then ifu");

    // Starvation: LSU valid continuously, IFU raised during LSU's RESP cycle
    lsu_addr = 32'h8000_3000; model_rdata = 32'h0000_0001; lsu_req_valid = 1;
    #1;
    chk("stv_first_lsu", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h2);
    step(); step(); step();
    ifu_req_valid = 1;
    step();
    chk("stv_lsu_wins_cnt1", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h2);
    repeat (4) step();
    chk("stv_ifu_wins_cnt4", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h1);
    repeat (4) step();
    chk("stv_cnt_cleared", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h2);
    step(); lsu_req_valid = 0;
    repeat (3) step();
    chk("stv_ifu_alone", {62'h0, lsu_req_ready, ifu_req_ready}, 64'h1);
    step(); ifu_req_valid = 0;
    repeat (3) step();
    $display("txn starvation sequence done");

    // Backpressure: ready low 5 cycles, response 3 cycles after accept
    req_delay = 5; resp_delay = 3;
    lrdy0 = lsu_rdy_cnt; lresp0 = lsu_resp_cnt; fc0 = field_changes;
    lsu_addr = 32'h8000_4000; lsu_wen = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 8'hFF;
    lsu_req_valid = 1;
    #1;
    chk("bp_ready", {63'h0, lsu_req_ready}, 64'h1);
    t0 = cyc;
    step(); lsu_req_valid = 0; lsu_wdata = 32'h0; lsu_addr = 32'h0;
    got = 0; n = 0;
    while (!got && n < 30) begin
      if (lsu_resp_valid) got = 1;
      else begin step(); n++; end
    end
    chk("bp_resp_seen", {63'h0, got}, 64'h1);
    chk("bp_resp_cycle", 64'(cyc - t0), 64'd11);
    step(); step();
    chk("bp_one_ready", 64'(lsu_rdy_cnt - lrdy0), 64'd1);
    chk("bp_one_resp", 64'(lsu_resp_cnt - lresp0), 64'd1);
    chk("bp_fields_stable", 64'(field_changes - fc0), 64'd0);
    chk("bp_fields", {snap_addr, snap_wdata}, {32'h8000_4000, 32'hCAFE_F00D});
    lsu_wen = 0; req_delay = 0; resp_delay = 10;
    $display("txn backpressure write addr=80004000");

    // Reset asserted mid-WAIT
    lsu_addr = 32'h8000_5000; lsu_req_valid = 1;
    #1;
    step(); lsu_req_valid = 0;
    step(); step();
    ifu_addr = 32'h8000_0008; ifu_req_valid = 1; model_rdata = 32'hABCD_0001;
    rst = 1'b1;
    #1;
    chk("rstw_ctrl", {58'h0, ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                      mem_req_valid, mem_wen}, 64'h0);
    chk("rstw_addr", {mem_addr, 24'h0, mem_wmask}, 64'h0);
    lresp0 = lsu_resp_cnt;
    resp_delay = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstw_ifu_ready", {63'h0, ifu_req_ready}, 64'h1);
    @(posedge clk); #1; ifu_req_valid = 0;
    chk("rstw_ifu_addr", mem_addr, 32'h8000_0008);
    step(); step();
    chk("rstw_ifu_resp", {63'h0, ifu_resp_valid}, 64'h1);
    chk("rstw_ifu_rdata", ifu_rdata, 32'hABCD_0001);
    repeat (12) step();
    chk("rstw_no_lsu_resp", 64'(lsu_resp_cnt - lresp0), 64'd0);
    $display("txn reset mid-wait then ifu fetch addr=80000008");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
